// File: rtl/mem_wb_pipe_buf.sv
// MEM->WB pipeline boundary: 2-entry skid buffer (head + skid) with valid/ready on both
// sides, freeze and synchronous flush. Optional forwarding taps under `MEM_WB_FWD_EN`.
module mem_wb_pipe_buf #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_read_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_read_value,
  output logic [DEST_W-1:0] dest,
  output logic [1:0]        occupancy
`ifdef MEM_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_value
`endif
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_read;
    logic [DEST_W-1:0] dest;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e     state_q;
  entry_t     head_q;
  entry_t     skid_q;
  logic [1:0] occ_q;

  entry_t in_ent;
  logic   head_valid;
  logic   skid_valid;
  logic   accept;
  logic   deliver;

  assign in_ent = '{wb_en:      wb_en_in,
                    mem_r_en:   mem_r_en_in,
                    pc:         pc_in,
                    alu_result: alu_result_in,
                    mem_read:   mem_read_in,
                    dest:       dest_in};

  assign head_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  // Held low while reset is asserted so nothing appears accepted during reset.
  assign in_ready  = rst & ~skid_valid & ~freeze & ~flush;
  assign out_valid = head_valid & ~freeze;
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  // Flush beats freeze; freeze holds everything including payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      occ_q   <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      occ_q   <= 2'd0;
    end else if (!freeze) begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_q  <= in_ent;
            state_q <= ONE;
            occ_q   <= 2'd1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            head_q <= in_ent;
          end else if (accept) begin
            skid_q  <= in_ent;
            state_q <= FULL;
            occ_q   <= 2'd2;
          end else if (deliver) begin
            state_q <= EMPTY;
            occ_q   <= 2'd0;
          end
        end
        FULL: begin
          if (deliver) begin
            head_q  <= skid_q;
            state_q <= ONE;
            occ_q   <= 2'd1;
          end
        end
        default: begin
          state_q <= EMPTY;
          occ_q   <= 2'd0;
        end
      endcase
    end
  end

  assign wb_en          = head_q.wb_en & out_valid;
  assign mem_r_en       = head_q.mem_r_en;
  assign pc             = head_q.pc;
  assign alu_result     = head_q.alu_result;
  assign mem_read_value = head_q.mem_read;
  assign dest           = head_q.dest;
  assign occupancy      = occ_q;

`ifdef MEM_WB_FWD_EN
  // Forwarding sees the head even while frozen; hazard logic still needs it.
  assign fwd_valid = head_valid & head_q.wb_en;
  assign fwd_dest  = head_q.dest;
  assign fwd_value = head_q.mem_r_en ? head_q.mem_read : head_q.alu_result;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_buf.sv
// Bench for mem_wb_pipe_buf: constant vector table, hand-built freeze/flush/reset/forwarding
// sequences, and random traffic against a queue-based model of the buffer.
module tb_mem_wb_pipe_buf;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid, in_ready;
  logic        wb_en_in, mem_r_en_in;
  logic [31:0] pc_in, alu_result_in, mem_read_in;
  logic [3:0]  dest_in;
  logic        out_valid, out_ready, wb_en, mem_r_en;
  logic [31:0] pc, alu_result, mem_read_value;
  logic [3:0]  dest;
  logic [1:0]  occupancy;
`ifdef MEM_WB_FWD_EN
  logic        fwd_valid;
  logic [3:0]  fwd_dest;
  logic [31:0] fwd_value;
`endif

  mem_wb_pipe_buf #(.DATA_W(32), .DEST_W(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .pc_in(pc_in), .alu_result_in(alu_result_in), .mem_read_in(mem_read_in), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .pc(pc), .alu_result(alu_result),
    .mem_read_value(mem_read_value), .dest(dest), .occupancy(occupancy)
`ifdef MEM_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mrd;
    logic [3:0]  dest;
  } ent_t;

  // Model: the buffer is a FIFO of at most 2 entries; head payload lingers when empty.
  ent_t q[$];
  ent_t last_h;

  typedef struct {
    bit          fz, fl, iv, ordy;
    logic [31:0] pcv;
    bit          e_ov, e_ir;
    logic [1:0]  e_occ;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] act_vec();
    return 128'({out_valid, in_ready, occupancy, wb_en, mem_r_en, pc, alu_result, mem_read_value, dest});
  endfunction

  function automatic ent_t head_m();
    return (q.size() != 0) ? q[0] : last_h;
  endfunction

  function automatic logic [127:0] exp_vec();
    ent_t h  = head_m();
    bit   ov = (q.size() != 0) && !freeze;
    bit   ir = (q.size() < 2) && !freeze && !flush;
    return 128'({ov, ir, 2'(q.size()), h.wb_en & ov, h.mem_r_en, h.pc, h.alu, h.mrd, h.dest});
  endfunction

  task automatic model_upd();
    bit acc, del;
    if (flush) begin
      q.delete();
    end else if (!freeze) begin
      del = (q.size() != 0) && out_ready;
      acc = in_valid && (q.size() < 2);
      if (del) void'(q.pop_front());
      if (acc) q.push_back('{wb_en_in, mem_r_en_in, pc_in, alu_result_in, mem_read_in, dest_in});
    end
    if (q.size() != 0) last_h = q[0];
  endtask

  task automatic half();
    #4;
  endtask

  task automatic edge_();
    @(posedge clk);
    model_upd();
    #1;
  endtask

  task automatic step(input bit do_chk, input string nm);
    ent_t h;
    half();
    if (do_chk) begin
      chk(nm, act_vec(), exp_vec());
`ifdef MEM_WB_FWD_EN
      h = head_m();
      chk({nm, "_fwd"}, 128'({fwd_valid, fwd_dest, fwd_value}),
          128'({(q.size() != 0) && h.wb_en, h.dest, h.mem_r_en ? h.mrd : h.alu}));
`else
      h = '0;
`endif
    end
    edge_();
  endtask

  initial begin
    // Expectations: outputs seen mid-cycle with this row's inputs applied.
    tbl[0]  = '{0,0,1,1,32'h10, 0,1,2'd0,32'h00};
    tbl[1]  = '{0,0,1,1,32'h14, 1,1,2'd1,32'h10};
    tbl[2]  = '{0,0,1,1,32'h18, 1,1,2'd1,32'h14};
    tbl[3]  = '{0,0,0,1,32'h00, 1,1,2'd1,32'h18};
    tbl[4]  = '{0,0,0,1,32'h00, 0,1,2'd0,32'h18};
    tbl[5]  = '{0,0,1,0,32'h20, 0,1,2'd0,32'h18};
    tbl[6]  = '{0,0,1,0,32'h24, 1,1,2'd1,32'h20};
    tbl[7]  = '{0,0,1,0,32'h28, 1,0,2'd2,32'h20};
    tbl[8]  = '{0,0,0,1,32'h00, 1,0,2'd2,32'h20};
    tbl[9]  = '{0,0,0,1,32'h00, 1,1,2'd1,32'h24};
    tbl[10] = '{0,0,0,0,32'h00, 0,1,2'd0,32'h24};
    tbl[11] = '{0,0,1,0,32'h30, 0,1,2'd0,32'h24};
    tbl[12] = '{0,0,1,0,32'h34, 1,1,2'd1,32'h30};
    tbl[13] = '{0,1,1,0,32'h38, 1,0,2'd2,32'h30};
    tbl[14] = '{0,0,0,1,32'h00, 0,1,2'd0,32'h30};
    tbl[15] = '{0,0,0,1,32'h00, 0,1,2'd0,32'h30};

    // T1 reset with live input
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1;
    pc_in = $urandom; alu_result_in = $urandom; mem_read_in = $urandom; dest_in = 4'($urandom);
    last_h = '0;
    repeat (2) @(posedge clk);
    #1; half();
    chk("reset_outs", 128'({out_valid, occupancy, wb_en, mem_r_en, pc, alu_result, mem_read_value, dest}), 128'(0));
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("reset_release", 128'({in_ready, occupancy}), 128'({1'b1, 2'd0}));
    edge_();

    // T2/T3/T5 vector table
    wb_en_in = 1'b1; mem_r_en_in = 1'b0; alu_result_in = 32'h0; mem_read_in = 32'h0; dest_in = 4'h1;
    for (int i = 0; i < 16; i++) begin
      freeze = tbl[i].fz; flush = tbl[i].fl; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      pc_in = tbl[i].pcv;
      half();
      chk($sformatf("vec%0d", i), 128'({out_valid, in_ready, occupancy, wb_en, pc}),
          128'({tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_occ, tbl[i].e_ov, tbl[i].e_pc}));
      edge_();
    end

    // T4 freeze holds one entry, then delivers it exactly once
    freeze = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    pc_in = 32'h50; dest_in = 4'h5; wb_en_in = 1'b1;
    step(1, "t4_load");
    for (int k = 0; k < 3; k++) begin
      freeze = 1'b1; in_valid = 1'b1; out_ready = 1'b1; pc_in = 32'h54; dest_in = 4'h9;
      half();
      chk($sformatf("t4_frz%0d", k), 128'({out_valid, wb_en, in_ready, dest, occupancy}),
          128'({1'b0, 1'b0, 1'b0, 4'h5, 2'd1}));
      edge_();
    end
    freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    half();
    chk("t4_release", 128'({out_valid, wb_en, dest, pc}), 128'({1'b1, 1'b1, 4'h5, 32'h50}));
    edge_();
    half();
    chk("t4_once", 128'({out_valid, occupancy}), 128'(0));
    edge_();

`ifdef MEM_WB_FWD_EN
    // T6 forwarding taps
    in_valid = 1'b1; out_ready = 1'b0; wb_en_in = 1'b1; mem_r_en_in = 1'b1;
    mem_read_in = 32'hDEAD; alu_result_in = 32'h40; dest_in = 4'h3; pc_in = 32'h60;
    step(1, "t6_load");
    in_valid = 1'b1; out_ready = 1'b1; mem_r_en_in = 1'b0; mem_read_in = 32'h1234;
    half();
    chk("t6_fwd_load", 128'({fwd_valid, fwd_dest, fwd_value}), 128'({1'b1, 4'h3, 32'hDEAD}));
    edge_();
    in_valid = 1'b0; out_ready = 1'b0; freeze = 1'b1;
    half();
    chk("t6_fwd_alu_frozen", 128'({fwd_valid, fwd_dest, fwd_value}), 128'({1'b1, 4'h3, 32'h40}));
    edge_();
    freeze = 1'b0; out_ready = 1'b1;
    step(1, "t6_drain");
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      freeze = ($urandom_range(0, 9) == 0); flush = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 9) < 6); out_ready = ($urandom_range(0, 9) < 5);
      wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom);
      pc_in = $urandom; alu_result_in = $urandom; mem_read_in = $urandom; dest_in = 4'($urandom);
      step(1, $sformatf("rand%0d", n));
    end

    // Asynchronous reset mid-operation while frozen and full
    freeze = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step(1, "fill_a");
    step(1, "fill_b");
    step(1, "fill_c");
    freeze = 1'b1; flush = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", 128'({out_valid, occupancy, wb_en, mem_r_en, pc, dest}), 128'(0));
    q.delete(); last_h = '0;
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    step(1, "post_reset");
    in_valid = 1'b1; out_ready = 1'b1; pc_in = 32'h70;
    step(1, "post_reset_acc");
    in_valid = 1'b0;
    step(1, "post_reset_out");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
